// File: rtl/stp16_meter_scheduler.sv
// stp16_meter_scheduler: level/peak-hold bar-graph frame builder and frame scheduler for the stp16cpc26 serializer.
// Ports: clk, reset (async, active-high); l_valid/l_level, r_valid/r_level level strobes (clamped to 16);
//        o_valid/o_ready frame handshake, data = {right bar, left bar}; tick = timebase pulse.
module stp16_meter_scheduler #(
  parameter int TICK_DIV      = 65536,
  parameter int HOLD_TICKS    = 32,
  parameter int REFRESH_TICKS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        l_valid,
  input  logic [4:0]  l_level,
  input  logic        r_valid,
  input  logic [4:0]  r_level,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [31:0] data,
  output logic        tick
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int RW = REFRESH_TICKS > 1 ? $clog2(REFRESH_TICKS) : 1;
  localparam logic IDLE = 1'b0;
  localparam logic SEND = 1'b1;
  logic [TW-1:0] tick_cnt;
  logic [RW-1:0] refresh_cnt;
  logic          refresh_pending;
  logic          refresh_wrap;
  logic          state;
  logic [31:0]   frame;
  logic [31:0]   sent_frame;
  assign tick         = tick_cnt == TW'(TICK_DIV - 1);
  assign refresh_wrap = tick && refresh_cnt == RW'(REFRESH_TICKS - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) tick_cnt <= '0;
    else tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic          vld;
    logic [4:0]    lin;
    logic [4:0]    v;
    logic [4:0]    level;
    logic [4:0]    peak;
    logic [4:0]    next_level;
    logic [HW-1:0] hold_cnt;
    assign vld        = c ? r_valid : l_valid;
    assign lin        = c ? r_level : l_level;
    assign v          = lin > 5'd16 ? 5'd16 : lin;
    // decay compares against the level being written this cycle so peak never drops below it
    assign next_level = vld ? v : level;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        level    <= '0;
        peak     <= '0;
        hold_cnt <= '0;
      end else begin
        if (vld) level <= v;
        if (vld && v >= peak) begin
          peak     <= v;
          hold_cnt <= HW'(HOLD_TICKS);
        end else if (tick) begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
          else if (peak > next_level) peak <= peak - 1'b1;
        end
      end
    // thermometer bar for the level, plus a single bit at peak-1 (empty when peak is 0)
    assign frame[16*c +: 16] = 16'(((17'd1 << level) - 17'd1) | ((17'd1 << peak) >> 1));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state           <= IDLE;
      o_valid         <= 1'b0;
      data            <= '0;
      sent_frame      <= '0;
      refresh_pending <= 1'b1;
      refresh_cnt     <= '0;
    end else begin
      if (tick) refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + 1'b1;
      refresh_pending <= refresh_wrap || (refresh_pending && !(o_valid && o_ready));
      if (state == IDLE) begin
        if (frame != sent_frame || refresh_pending) begin
          data    <= frame;
          o_valid <= 1'b1;
          state   <= SEND;
        end
      end else if (o_ready) begin
        o_valid    <= 1'b0;
        sent_frame <= data;
        state      <= IDLE;
      end
    end
endmodule

// File: tb/tb_stp16_meter_scheduler.sv
// tb_stp16_meter_scheduler: directed self-checking bench for stp16_meter_scheduler.
module tb_stp16_meter_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        l_valid = 1'b0;
  logic [4:0]  l_level = '0;
  logic        r_valid = 1'b0;
  logic [4:0]  r_level = '0;
  logic        o_ready = 1'b1;
  logic        o_valid;
  logic [31:0] data;
  logic        tick;
  int          checks = 0;
  int          failures = 0;
  int          n;
  logic [31:0] last = '0;
  stp16_meter_scheduler #(.TICK_DIV(4), .HOLD_TICKS(2), .REFRESH_TICKS(8)) dut (
    .clk(clk), .reset(reset),
    .l_valid(l_valid), .l_level(l_level),
    .r_valid(r_valid), .r_level(r_level),
    .o_valid(o_valid), .o_ready(o_ready),
    .data(data), .tick(tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic pulse(input logic lv, input logic [4:0] l, input logic rv, input logic [4:0] r);
    l_valid = lv;
    l_level = l;
    r_valid = rv;
    r_level = r;
    @(negedge clk);
    l_valid = 1'b0;
    r_valid = 1'b0;
  endtask
  task automatic get_frame(input string tag, input logic [31:0] exp, input bit rep, input int limit);
    bit found;
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++)
      if (o_valid === 1'b1 && o_ready && (rep || data !== last)) found = 1'b1;
      else @(negedge clk);
    chk(tag, found ? data : 32'hxxxxxxxx, exp);
    if (found) begin
      last = data;
      @(negedge clk);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_tick", {31'b0, tick}, 32'd0);
    reset = 1'b0;
    get_frame("first_zero", 32'h0, 1'b1, 3);
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (o_valid) n++;
    end
    chk("quiet", n, 0);
    get_frame("refresh_zero", 32'h0, 1'b1, 12);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      n += int'(tick);
    end
    chk("tick_count", n, 10);
    pulse(1'b1, 5'd5, 1'b0, 5'd0);
    get_frame("l5", 32'h0000001F, 1'b0, 10);
    pulse(1'b1, 5'd2, 1'b0, 5'd0);
    get_frame("l2", 32'h00000013, 1'b0, 10);
    get_frame("decay_b", 32'h0000000B, 1'b0, 40);
    get_frame("decay_7", 32'h00000007, 1'b0, 40);
    get_frame("decay_3", 32'h00000003, 1'b0, 40);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_valid && data !== 32'h3) n++;
    end
    chk("stable", n, 0);
    pulse(1'b1, 5'd16, 1'b1, 5'd20);
    get_frame("clamp", 32'hFFFFFFFF, 1'b0, 10);
    reset = 1'b1;
    o_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4 && o_valid !== 1'b1; i++) @(negedge clk);
    chk("stall_valid", {31'b0, o_valid}, 32'd1);
    chk("stall_snap", data, 32'h0);
    pulse(1'b1, 5'd4, 1'b1, 5'd8);
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (o_valid !== 1'b1 || data !== 32'h0) n++;
    end
    chk("stall_hold", n, 0);
    o_ready = 1'b1;
    last = '0;
    get_frame("stall_release", 32'h0, 1'b1, 2);
    get_frame("stall_latest", 32'h00FF000F, 1'b0, 6);
    o_ready = 1'b0;
    pulse(1'b1, 5'd6, 1'b0, 5'd0);
    for (int i = 0; i < 4 && o_valid !== 1'b1; i++) @(negedge clk);
    chk("pre_reset_data", data, 32'h00FF003F);
    #1 reset = 1'b1;
    #1;
    chk("reset_valid_drop", {31'b0, o_valid}, 32'd0);
    chk("reset_data", data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    o_ready = 1'b1;
    last = '0;
    get_frame("reset_zero", 32'h0, 1'b1, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
